// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters for RAW/load-use stall detection.
// Optional write-through forwarding from write-back to the read ports: define REGFILE_BYPASS_EN.
`timescale 1ns/1ps

module regfile_scoreboard #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 3,
  parameter int              NUM_RD   = 2,
  parameter int              PEND_W   = 2,
  parameter logic [DATA_W-1:0] BA_RESET = 16'h0040
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_issue_en,
  input  logic [ADDR_W-1:0]          i_issue_addr,
  output logic                       o_issue_ready,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_flush,
  output logic                       o_sb_err
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0] r_cnt  [NUM_REGS];
  logic              r_sb_err;

  logic [ADDR_W-1:0] w_rd_addr [NUM_RD];
  logic              w_same_addr;

  assign w_same_addr = i_issue_en && i_wr_en && (i_issue_addr == i_wr_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs[0] <= BA_RESET;
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Flush beats everything; an issue and a release of the same register cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_sb_err <= 1'b0;
    end else if (i_flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (!w_same_addr) begin
      if (i_issue_en) begin
        if (r_cnt[i_issue_addr] != CNT_MAX) begin
          r_cnt[i_issue_addr] <= r_cnt[i_issue_addr] + PEND_W'(1);
        end else begin
          r_sb_err <= 1'b1;
        end
      end
      if (i_wr_en) begin
        if (r_cnt[i_wr_addr] != '0) begin
          r_cnt[i_wr_addr] <= r_cnt[i_wr_addr] - PEND_W'(1);
        end else begin
          r_sb_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      o_rd_data[k*DATA_W +: DATA_W] = r_regs[w_rd_addr[k]];
      o_rd_busy[k]                  = (r_cnt[w_rd_addr[k]] != '0);
`ifdef REGFILE_BYPASS_EN
      // The last outstanding write landing this cycle clears the hazard immediately.
      if (i_wr_en && (i_wr_addr == w_rd_addr[k])) begin
        o_rd_data[k*DATA_W +: DATA_W] = i_wr_data;
        if (r_cnt[w_rd_addr[k]] == PEND_W'(1)) begin
          o_rd_busy[k] = 1'b0;
        end
      end
`endif
    end
  end

  assign o_issue_ready = (r_cnt[i_issue_addr] != CNT_MAX);
  assign o_sb_err      = r_sb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled.
`timescale 1ns/1ps

module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        issue_en;
  logic [2:0]  issue_addr;
  logic        issue_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        flush;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t exp_q[$];

  regfile_scoreboard dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .o_issue_ready(issue_ready),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_flush      (flush),
    .o_sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Port 1 address in the upper field, port 0 in the lower.
  task automatic set_rd(input logic [2:0] a1, input logic [2:0] a0);
    rd_addr = {a1, a0};
  endtask

  // Apply one edge, then drop the strobes; sampling happens 1ns+ after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    issue_en = 1'b0;
    wr_en    = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    issue_en   = 1'b0;
    issue_addr = 3'd0;
    wr_en      = 1'b0;
    wr_addr    = 3'd0;
    wr_data    = 16'h0000;
    flush      = 1'b0;
    set_rd(3'd5, 3'd0);

    // Reset contents while reset is held and after release
    repeat (2) @(posedge clk);
    #2;
    expect_v("rst_rd_data", 32'h0000_0040);   observe(rd_data);
    expect_v("rst_rd_busy", 32'd0);           observe({30'd0, rd_busy});
    expect_v("rst_issue_ready", 32'd1);       observe({31'd0, issue_ready});
    expect_v("rst_sb_err", 32'd0);            observe({31'd0, sb_err});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_v("post_rst_rd_data", 32'h0000_0040); observe(rd_data);
    expect_v("post_rst_rd_busy", 32'd0);         observe({30'd0, rd_busy});

    // Reserve r4 at edge 1, release it at edge 3
    set_rd(3'd5, 3'd4);
    issue_en   = 1'b1;
    issue_addr = 3'd4;
    expect_v("res_issue_ready", 32'd1);       observe({31'd0, issue_ready});
    expect_v("res_busy_edge1", 32'd1);
    tick();
    observe({31'd0, rd_busy[0]});
    expect_v("res_busy_edge2", 32'd1);
    tick();
    observe({31'd0, rd_busy[0]});
    wr_en   = 1'b1;
    wr_addr = 3'd4;
    wr_data = 16'h1234;
    #1;
    expect_v("res_wb_cycle_data", BYP ? 32'h1234 : 32'h0000);  observe({16'd0, rd_data[15:0]});
    expect_v("res_wb_cycle_busy", BYP ? 32'd0 : 32'd1);        observe({31'd0, rd_busy[0]});
    tick();
    expect_v("res_after_data", 32'h1234);     observe({16'd0, rd_data[15:0]});
    expect_v("res_after_busy", 32'd0);        observe({31'd0, rd_busy[0]});

    // Simultaneous issue and write-back to r6 with one write pending
    set_rd(3'd6, 3'd4);
    issue_en   = 1'b1;
    issue_addr = 3'd6;
    tick();
    expect_v("r6_busy_pre", 32'd1);           observe({31'd0, rd_busy[1]});
    issue_en   = 1'b1;
    issue_addr = 3'd6;
    wr_en      = 1'b1;
    wr_addr    = 3'd6;
    wr_data    = 16'h6666;
    tick();
    expect_v("r6_busy_same", 32'd1);          observe({31'd0, rd_busy[1]});
    expect_v("r6_data_same", 32'h6666);       observe({16'd0, rd_data[31:16]});
    expect_v("r6_no_err", 32'd0);             observe({31'd0, sb_err});
    wr_en   = 1'b1;
    wr_addr = 3'd6;
    tick();
    expect_v("r6_busy_release", 32'd0);       observe({31'd0, rd_busy[1]});
    expect_v("r6_release_no_err", 32'd0);     observe({31'd0, sb_err});

    // Saturate r3: three issues fill it, the fourth overflows
    set_rd(3'd0, 3'd3);
    issue_addr = 3'd3;
    expect_v("sat_ready_initial", 32'd1);     observe({31'd0, issue_ready});
    for (int i = 0; i < 3; i++) begin
      issue_en = 1'b1;
      tick();
    end
    expect_v("sat_ready_full", 32'd0);        observe({31'd0, issue_ready});
    expect_v("sat_err_before_ovf", 32'd0);    observe({31'd0, sb_err});
    issue_en = 1'b1;
    tick();
    expect_v("sat_err_ovf", 32'd1);           observe({31'd0, sb_err});
    expect_v("sat_ready_held", 32'd0);        observe({31'd0, issue_ready});
    // Counter must be held at 3: two releases leave it busy, the third frees it
    for (int i = 0; i < 2; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'd3;
      wr_data = 16'h3333;
      tick();
    end
    expect_v("sat_cnt_still_pending", 32'd1); observe({31'd0, rd_busy[0]});
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    tick();
    expect_v("sat_cnt_drained", 32'd0);       observe({31'd0, rd_busy[0]});
    // Register 0 is writable
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 16'hAAAA;
    tick();
    expect_v("r0_write", 32'hAAAA);           observe({16'd0, rd_data[31:16]});

    // Async reset between edges with a write pending on r1
    set_rd(3'd0, 3'd1);
    issue_en   = 1'b1;
    issue_addr = 3'd1;
    tick();
    expect_v("arst_busy_before", 32'd1);      observe({31'd0, rd_busy[0]});
    #2;
    rst_n = 1'b0;
    #1;
    expect_v("arst_busy_now", 32'd0);         observe({31'd0, rd_busy[0]});
    expect_v("arst_r0_now", 32'h0040);        observe({16'd0, rd_data[31:16]});
    expect_v("arst_err_now", 32'd0);          observe({31'd0, sb_err});
    expect_v("arst_ready_now", 32'd1);        observe({31'd0, issue_ready});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write-back with nothing pending: error flagged, data still written
    set_rd(3'd7, 3'd0);
    wr_en   = 1'b1;
    wr_addr = 3'd7;
    wr_data = 16'h7777;
    tick();
    expect_v("unf_err", 32'd1);               observe({31'd0, sb_err});
    expect_v("unf_data", 32'h7777);           observe({16'd0, rd_data[31:16]});
    expect_v("unf_busy", 32'd0);              observe({31'd0, rd_busy[1]});

    // Flush with cnt[2]=2, cnt[5]=1 plus same-cycle issue and write-back
    set_rd(3'd5, 3'd2);
    issue_addr = 3'd2;
    issue_en   = 1'b1;
    tick();
    issue_en   = 1'b1;
    tick();
    issue_addr = 3'd5;
    issue_en   = 1'b1;
    tick();
    expect_v("fl_busy_before", 32'd3);        observe({30'd0, rd_busy});
    flush      = 1'b1;
    issue_en   = 1'b1;
    issue_addr = 3'd2;
    wr_en      = 1'b1;
    wr_addr    = 3'd5;
    wr_data    = 16'hBEEF;
    tick();
    expect_v("fl_busy_after", 32'd0);         observe({30'd0, rd_busy});
    expect_v("fl_wr_data", 32'hBEEF);         observe({16'd0, rd_data[31:16]});
    expect_v("fl_r2_data", 32'h0000);         observe({16'd0, rd_data[15:0]});
    expect_v("fl_ready_r2", 32'd1);           observe({31'd0, issue_ready});

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d unchecked expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
